gain_ramp_ctrl: RTL and testbench

//   Drives the gain input of a gain_stage instance. Replaces abrupt gain changes with a

---
 rtl/gain_ctrl_pkg.sv | 14 +
 rtl/gain_ramp_step.sv | 40 ++++
 rtl/gain_ramp_ctrl.sv | 110 +++++++++++
 tb/tb_gain_ramp_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gain_ctrl_pkg.sv
// Shared types and helpers for the gain ramp controller.
package gain_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

  function automatic logic [63:0] gain_unity(input int unsigned dec_bits);
    return 64'd1 << dec_bits;
  endfunction

endpackage

// File: rtl/gain_ramp_step.sv
// One ramp step: advances gain toward eff_t by step, clamping exactly onto the target.
module gain_ramp_step #(
  parameter int unsigned GW = 32
) (
  input  logic [GW-1:0] gain_i,
  input  logic [GW-1:0] step_i,
  input  logic [GW-1:0] eff_t_i,
  input  logic          dir_up_i,
  output logic [GW-1:0] gain_o,
  output logic          hit_o
);

  logic [GW:0] sum;
  logic [GW:0] thr;

  // One extra bit so neither gain+step nor eff_t+step can wrap.
  assign sum = {1'b0, gain_i} + {1'b0, step_i};
  assign thr = {1'b0, eff_t_i} + {1'b0, step_i};

  always_comb begin
    gain_o = gain_i;
    hit_o  = 1'b0;
    if (dir_up_i) begin
      if (sum >= {1'b0, eff_t_i}) begin
        gain_o = eff_t_i;
        hit_o  = 1'b1;
      end else begin
        gain_o = sum[GW-1:0];
      end
    end else begin
      if ({1'b0, gain_i} <= thr) begin
        gain_o = eff_t_i;
        hit_o  = 1'b1;
      end else begin
        gain_o = gain_i - step_i;
      end
    end
  end

endmodule

// File: rtl/gain_ramp_ctrl.sv
// Sample-paced linear gain ramp toward a programmed target.
// Optional GAIN_RAMP_MUTE_EN adds mute/muted (ramp to zero while mute is high).
module gain_ramp_ctrl
  import gain_ctrl_pkg::*;
#(
  parameter int unsigned  G_INTEGER_BITS = 16,
  parameter int unsigned  G_DECIMAL_BITS = 16,
  parameter logic [63:0]  G_RESET_GAIN   = gain_unity(16),
  localparam int unsigned GW             = G_INTEGER_BITS + G_DECIMAL_BITS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [GW-1:0] target_gain,
  input  logic          target_valid,
  input  logic [GW-1:0] step,
  input  logic          sample_tick,
  output logic [GW-1:0] gain,
  output logic          ramp_busy,
  output logic          ramp_done
`ifdef GAIN_RAMP_MUTE_EN
  ,
  input  logic          mute,
  output logic          muted
`endif
);

  localparam logic [GW-1:0] ResetGain = GW'(G_RESET_GAIN);

  ramp_state_t   state_q;
  logic [GW-1:0] gain_q;
  logic [GW-1:0] target_q;
  logic          done_q;
  logic          eval_q;
  logic [GW-1:0] eff_t;
  logic          mute_edge;
  logic [GW-1:0] next_gain;
  logic          hit;

`ifdef GAIN_RAMP_MUTE_EN
  logic mute_q;
  assign eff_t     = mute_q ? '0 : target_q;
  assign mute_edge = mute ^ mute_q;
  assign muted     = mute_q && (gain_q == '0);
`else
  assign eff_t     = target_q;
  assign mute_edge = 1'b0;
`endif

  gain_ramp_step #(
    .GW(GW)
  ) u_step (
    .gain_i  (gain_q),
    .step_i  (step),
    .eff_t_i (eff_t),
    .dir_up_i(state_q == RAMP_UP),
    .gain_o  (next_gain),
    .hit_o   (hit)
  );

  // A load (or mute change) only latches; direction is chosen on the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gain_q   <= ResetGain;
      target_q <= ResetGain;
      done_q   <= 1'b0;
      eval_q   <= 1'b0;
`ifdef GAIN_RAMP_MUTE_EN
      mute_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (enable) begin
        if (target_valid || mute_edge) begin
          if (target_valid) target_q <= target_gain;
`ifdef GAIN_RAMP_MUTE_EN
          mute_q <= mute;
`endif
          eval_q <= 1'b1;
        end else if (eval_q) begin
          eval_q <= 1'b0;
          if (eff_t == gain_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (step == '0) begin
            gain_q  <= eff_t;
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (eff_t > gain_q) begin
            state_q <= RAMP_UP;
          end else begin
            state_q <= RAMP_DOWN;
          end
        end else if (sample_tick && (state_q != IDLE)) begin
          gain_q <= next_gain;
          if (hit) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign gain      = gain_q;
  assign ramp_busy = (state_q != IDLE);
  assign ramp_done = done_q;

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Self-checking bench for gain_ramp_ctrl: directed literal cases plus randomized traffic
// checked every cycle against a behavioural model.
module tb_gain_ramp_ctrl;

`ifdef GAIN_RAMP_MUTE_EN
  localparam bit MuteEn = 1'b1;
`else
  localparam bit MuteEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b1;
  logic        target_valid = 1'b0;
  logic        sample_tick = 1'b0;
  logic        mute = 1'b0;
  logic [31:0] target_gain = '0;
  logic [31:0] step = '0;
  logic [31:0] gain;
  logic        ramp_busy;
  logic        ramp_done;
  logic        muted;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  gain_ramp_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .target_gain (target_gain),
    .target_valid(target_valid),
    .step        (step),
    .sample_tick (sample_tick),
    .gain        (gain),
    .ramp_busy   (ramp_busy),
    .ramp_done   (ramp_done)
`ifdef GAIN_RAMP_MUTE_EN
    ,
    .mute        (mute),
    .muted       (muted)
`endif
  );

`ifndef GAIN_RAMP_MUTE_EN
  assign muted = 1'b0;
`endif

  // Behavioural model: gain as a plain integer, direction as -1/0/+1.
  longint m_gain = 64'h1_0000;
  longint m_tgt  = 64'h1_0000;
  int     m_dir  = 0;
  bit     m_eval = 1'b0;
  bit     m_done = 1'b0;
  bit     m_mute = 1'b0;

  always @(posedge clk or negedge reset_n) begin : model
    longint e, g;
    if (!reset_n) begin
      m_gain = 64'h1_0000;
      m_tgt  = 64'h1_0000;
      m_dir  = 0;
      m_eval = 1'b0;
      m_done = 1'b0;
      m_mute = 1'b0;
    end else begin
      m_done = 1'b0;
      if (enable) begin
        if (target_valid || (MuteEn && (mute != m_mute))) begin
          if (target_valid) m_tgt = longint'(target_gain);
          if (MuteEn) m_mute = mute;
          m_eval = 1'b1;
        end else if (m_eval) begin
          m_eval = 1'b0;
          e = m_mute ? 0 : m_tgt;
          if (e == m_gain) begin
            m_dir  = 0;
            m_done = 1'b1;
          end else if (step == 0) begin
            m_gain = e;
            m_dir  = 0;
            m_done = 1'b1;
          end else begin
            m_dir = (e > m_gain) ? 1 : -1;
          end
        end else if (sample_tick && (m_dir != 0)) begin
          e = m_mute ? 0 : m_tgt;
          g = m_gain + m_dir * longint'(step);
          if ((m_dir > 0 && g >= e) || (m_dir < 0 && g <= e)) g = e;
          if (g == e) begin
            m_dir  = 0;
            m_done = 1'b1;
          end
          m_gain = g;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_gain", {32'h0, gain}, m_gain);
    check("model_busy", {63'h0, ramp_busy}, {63'h0, (m_dir != 0)});
    check("model_done", {63'h0, ramp_done}, {63'h0, m_done});
    if (MuteEn) check("model_muted", {63'h0, muted}, {63'h0, (m_mute && m_gain == 0)});
    if (ramp_done) done_cnt++;
  end

  task automatic drive(input logic tv, input logic [31:0] tg, input logic tk);
    target_valid = tv;
    target_gain  = tg;
    sample_tick  = tk;
    @(posedge clk);
    #1;
    target_valid = 1'b0;
    sample_tick  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    #2;
    do_reset();
    check("reset_gain", {32'h0, gain}, 64'h1_0000);
    check("reset_busy", {63'h0, ramp_busy}, 64'h0);
    check("reset_done", {63'h0, ramp_done}, 64'h0);

    // Ramp up in four ticks.
    done_cnt = 0;
    step = 32'h0000_8000;
    drive(1'b1, 32'h0003_0000, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    check("up_busy", {63'h0, ramp_busy}, 64'h1);
    drive(1'b0, 32'h0, 1'b1);
    check("up_t1", {32'h0, gain}, 64'h1_8000);
    drive(1'b0, 32'h0, 1'b1);
    check("up_t2", {32'h0, gain}, 64'h2_0000);
    drive(1'b0, 32'h0, 1'b1);
    check("up_t3", {32'h0, gain}, 64'h2_8000);
    drive(1'b0, 32'h0, 1'b1);
    check("up_t4", {32'h0, gain}, 64'h3_0000);
    check("up_done", {63'h0, ramp_done}, 64'h1);
    drive(1'b0, 32'h0, 1'b1);
    check("up_done_cnt", 64'(done_cnt), 64'd1);

    // Down with a step larger than the remaining distance.
    step = 32'h0003_0000;
    drive(1'b1, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    check("down_clamp", {32'h0, gain}, 64'h0);
    check("down_done", {63'h0, ramp_done}, 64'h1);
    drive(1'b0, 32'h0, 1'b0);

    // Zero step jumps straight to the target without a tick.
    step = 32'h0;
    drive(1'b1, 32'h0000_4000, 1'b0);
    check("step0_hold", {32'h0, gain}, 64'h0);
    drive(1'b0, 32'h0, 1'b0);
    check("step0_gain", {32'h0, gain}, 64'h4000);
    check("step0_done", {63'h0, ramp_done}, 64'h1);

    // Retarget mid-ramp: one completion only.
    drive(1'b1, 32'h0001_0000, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    done_cnt = 0;
    step = 32'h0001_0000;
    drive(1'b1, 32'h0004_0000, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    check("rt_t1", {32'h0, gain}, 64'h2_0000);
    drive(1'b1, 32'h0000_8000, 1'b1);
    check("rt_load_wins", {32'h0, gain}, 64'h2_0000);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    check("rt_t2", {32'h0, gain}, 64'h1_0000);
    drive(1'b0, 32'h0, 1'b1);
    check("rt_t3", {32'h0, gain}, 64'h8000);
    drive(1'b0, 32'h0, 1'b1);
    check("rt_done_cnt", 64'(done_cnt), 64'd1);

    // Asynchronous reset in the middle of a ramp.
    drive(1'b1, 32'h0004_0000, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_gain", {32'h0, gain}, 64'h1_0000);
    check("arst_busy", {63'h0, ramp_busy}, 64'h0);
    check("arst_done", {63'h0, ramp_done}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef GAIN_RAMP_MUTE_EN
    step = 32'h0001_0000;
    drive(1'b1, 32'h0002_0000, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    check("mute_pre", {32'h0, gain}, 64'h2_0000);
    mute = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    check("mute_t1", {32'h0, gain}, 64'h1_0000);
    drive(1'b0, 32'h0, 1'b1);
    check("mute_t2", {32'h0, gain}, 64'h0);
    check("muted", {63'h0, muted}, 64'h1);
    mute = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    check("unmute_t1", {32'h0, gain}, 64'h1_0000);
    drive(1'b0, 32'h0, 1'b1);
    check("unmute_t2", {32'h0, gain}, 64'h2_0000);
    check("unmuted", {63'h0, muted}, 64'h0);
`endif

    // Randomized traffic, checked by the model each cycle.
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 3);
        case (r)
          0:       step = 32'h0;
          1:       step = $urandom_range(1, 32'h4000);
          2:       step = $urandom_range(32'h8000, 32'h3_0000);
          default: step = 32'hF000_0000;
        endcase
      end
      if (MuteEn && $urandom_range(0, 59) == 0) mute = ~mute;
      r = $urandom_range(0, 19);
      if (i == 2000) begin
        do_reset();
      end else begin
        drive(($urandom_range(0, 24) == 0),
              (r == 0) ? 32'hFFFF_FFF0 - $urandom_range(0, 255) : $urandom_range(0, 32'h8_0000),
              $urandom_range(0, 1) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
